wb_sram_bridge: RTL and testbench

Wishbone pipelined-mode slave that sits directly downstream of the bus master and turns each accepted request into one timed access on the external asynchronous SRAM. Handles single-beat requests where strobe is held for one accepted cycle and cycle is held until ack. Wait states are configurable. Back-to-back requests are accepted during the ack cycle.

---
 rtl/wb_sram_bridge_if.sv | 38 +++
 rtl/wb_sram_bridge.sv | 169 ++++++++++++++++
 tb/tb_wb_sram_bridge.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sram_bridge_if.sv
// ---------------------------------------------------------------------------
// wb_sram_bridge_if
//   Wishbone pipelined-mode request/response signals between a bus master
//   and the wb_sram_bridge slave.
//
//   Signals (directions as seen by the slave):
//     wb_addr_i   in   request address
//     wb_data_i   in   write data
//     wb_data_o   out  read data, valid while wb_ack_o=1 on reads
//     wb_we_i     in   1=write, 0=read
//     wb_cycle_i  in   bus cycle active
//     wb_strobe_i in   request valid
//     wb_stall_o  out  1=request not accepted this cycle
//     wb_ack_o    out  one-cycle completion pulse
// ---------------------------------------------------------------------------
interface wb_sram_bridge_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 17
);
    logic [ADDR_WIDTH-1:0] wb_addr_i;
    logic [DATA_WIDTH-1:0] wb_data_i;
    logic [DATA_WIDTH-1:0] wb_data_o;
    logic                  wb_we_i;
    logic                  wb_cycle_i;
    logic                  wb_strobe_i;
    logic                  wb_stall_o;
    logic                  wb_ack_o;

    modport master (
        output wb_addr_i, wb_data_i, wb_we_i, wb_cycle_i, wb_strobe_i,
        input  wb_data_o, wb_stall_o, wb_ack_o
    );

    modport slave (
        input  wb_addr_i, wb_data_i, wb_we_i, wb_cycle_i, wb_strobe_i,
        output wb_data_o, wb_stall_o, wb_ack_o
    );
endinterface

// File: rtl/wb_sram_bridge.sv
// ---------------------------------------------------------------------------
// wb_sram_bridge
//   Wishbone pipelined-mode slave that turns each accepted single-beat
//   request into one timed access on an external asynchronous SRAM:
//   SETUP (1 cycle) -> ACCESS (WAIT_STATES+1 cycles, strobe low) ->
//   HOLD (1 cycle, ack). A new request can be accepted in the HOLD cycle,
//   giving one access per WAIT_STATES+3 cycles back to back.
//
//   Parameters:
//     DATA_WIDTH   data bus width (Wishbone and SRAM)
//     ADDR_WIDTH   address width (Wishbone and SRAM)
//     WAIT_STATES  extra SRAM strobe cycles beyond the minimum of 1 (0..15)
//
//   Ports:
//     wb_clock_i     in   sole clock, rising edge
//     wb_reset_n_i   in   synchronous active-low reset
//     wb             slave modport of wb_sram_bridge_if (Wishbone side)
//     ram_addr_o     out  SRAM address
//     ram_data_i     in   SRAM read data from pad
//     ram_data_o     out  SRAM write data to pad
//     ram_data_oe_o  out  pad output enable for ram_data_o
//     ram_we_n_o     out  SRAM write enable, active-low
//     ram_oe_n_o     out  SRAM output enable, active-low
//
//   Optional feature:
//     WB_SRAM_ABORT_EN  when defined, wb_cycle_i=0 sampled in SETUP or
//                       ACCESS abandons the access and returns to IDLE
//                       without an ack. When undefined the access always
//                       completes and the ack is masked by wb_cycle_i.
// ---------------------------------------------------------------------------
module wb_sram_bridge #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 17,
    parameter int WAIT_STATES = 2
) (
    input  logic                  wb_clock_i,
    input  logic                  wb_reset_n_i,
    wb_sram_bridge_if.slave       wb,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    input  logic [DATA_WIDTH-1:0] ram_data_i,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    output logic                  ram_data_oe_o,
    output logic                  ram_we_n_o,
    output logic                  ram_oe_n_o
);
    localparam logic [3:0] LP_WAIT = WAIT_STATES[3:0];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_HOLD
    } state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_we;
    logic                  r_stall;
    logic                  r_ack_arm;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_wdata;
    logic                  r_ram_data_oe;
    logic                  r_ram_we_n;
    logic                  r_ram_oe_n;

    logic                  w_accept;
    logic                  w_abort;

    assign w_accept = wb.wb_cycle_i & wb.wb_strobe_i & ~r_stall;

`ifdef WB_SRAM_ABORT_EN
    assign w_abort = ~wb.wb_cycle_i;
`else
    assign w_abort = 1'b0;
`endif

    // Ack is the registered HOLD flag gated by the live cycle signal, so a
    // master that dropped cycle mid-access never sees a stray ack.
    assign wb.wb_ack_o   = r_ack_arm & wb.wb_cycle_i;
    assign wb.wb_stall_o = r_stall;
    assign wb.wb_data_o  = r_rdata;

    assign ram_addr_o    = r_ram_addr;
    assign ram_data_o    = r_ram_wdata;
    assign ram_data_oe_o = r_ram_data_oe;
    assign ram_we_n_o    = r_ram_we_n;
    assign ram_oe_n_o    = r_ram_oe_n;

    always_ff @(posedge wb_clock_i) begin
        if (!wb_reset_n_i) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_we          <= 1'b0;
            r_stall       <= 1'b0;
            r_ack_arm     <= 1'b0;
            r_rdata       <= '0;
            r_ram_addr    <= '0;
            r_ram_wdata   <= '0;
            r_ram_data_oe <= 1'b0;
            r_ram_we_n    <= 1'b1;
            r_ram_oe_n    <= 1'b1;
        end else begin
            case (r_state)
                // IDLE and HOLD share acceptance: HOLD is the ack cycle and
                // may take the next request directly into SETUP.
                ST_IDLE, ST_HOLD: begin
                    r_ack_arm <= 1'b0;
                    if (w_accept) begin
                        r_state       <= ST_SETUP;
                        r_ram_addr    <= wb.wb_addr_i;
                        r_ram_wdata   <= wb.wb_data_i;
                        r_we          <= wb.wb_we_i;
                        r_ram_data_oe <= wb.wb_we_i;
                        r_stall       <= 1'b1;
                    end else begin
                        r_state       <= ST_IDLE;
                        r_ram_data_oe <= 1'b0;
                    end
                end

                ST_SETUP: begin
                    if (w_abort) begin
                        r_state       <= ST_IDLE;
                        r_stall       <= 1'b0;
                        r_ram_data_oe <= 1'b0;
                    end else begin
                        r_state    <= ST_ACCESS;
                        r_cnt      <= LP_WAIT;
                        r_ram_we_n <= ~r_we;
                        r_ram_oe_n <= r_we;
                    end
                end

                ST_ACCESS: begin
                    if (w_abort) begin
                        r_state       <= ST_IDLE;
                        r_stall       <= 1'b0;
                        r_ram_data_oe <= 1'b0;
                        r_ram_we_n    <= 1'b1;
                        r_ram_oe_n    <= 1'b1;
                    end else if (r_cnt == 4'd0) begin
                        r_state    <= ST_HOLD;
                        r_stall    <= 1'b0;
                        r_ack_arm  <= 1'b1;
                        r_ram_we_n <= 1'b1;
                        r_ram_oe_n <= 1'b1;
                        // Output enable is still low on this edge, so the
                        // pad data is valid to capture.
                        if (!r_we) begin
                            r_rdata <= ram_data_i;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                default: begin
                    r_state       <= ST_IDLE;
                    r_stall       <= 1'b0;
                    r_ack_arm     <= 1'b0;
                    r_ram_data_oe <= 1'b0;
                    r_ram_we_n    <= 1'b1;
                    r_ram_oe_n    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_sram_bridge.sv
// ---------------------------------------------------------------------------
// tb_wb_sram_bridge
//   Directed bench for wb_sram_bridge. Three instances: W=2 (default) with
//   a byte-array SRAM model, W=0 and W=15 with a pad that returns 0xA3
//   while output enable is low. Inputs change and outputs are sampled on
//   the falling edge; "k" below counts falling edges after the acceptance
//   edge E0, so an ack seen at step k is sampled by the master at E(k+1).
// ---------------------------------------------------------------------------
module tb_wb_sram_bridge;
    logic clk;
    logic rst_n;

    int errors = 0;
    int checks = 0;

    wb_sram_bridge_if #(.DATA_WIDTH(8), .ADDR_WIDTH(17)) if0 ();
    wb_sram_bridge_if #(.DATA_WIDTH(8), .ADDR_WIDTH(17)) if1 ();
    wb_sram_bridge_if #(.DATA_WIDTH(8), .ADDR_WIDTH(17)) if2 ();

    logic [16:0] ram_addr0, ram_addr1, ram_addr2;
    logic [7:0]  ram_di0, ram_di1, ram_di2;
    logic [7:0]  ram_do0, ram_do1, ram_do2;
    logic        ram_oe0, ram_oe1, ram_oe2;
    logic        ram_wen0, ram_wen1, ram_wen2;
    logic        ram_oen0, ram_oen1, ram_oen2;

    logic [7:0]  mem [0:131071];

    wb_sram_bridge #(.DATA_WIDTH(8), .ADDR_WIDTH(17), .WAIT_STATES(2)) dut0 (
        .wb_clock_i(clk), .wb_reset_n_i(rst_n), .wb(if0),
        .ram_addr_o(ram_addr0), .ram_data_i(ram_di0), .ram_data_o(ram_do0),
        .ram_data_oe_o(ram_oe0), .ram_we_n_o(ram_wen0), .ram_oe_n_o(ram_oen0)
    );

    wb_sram_bridge #(.DATA_WIDTH(8), .ADDR_WIDTH(17), .WAIT_STATES(0)) dut1 (
        .wb_clock_i(clk), .wb_reset_n_i(rst_n), .wb(if1),
        .ram_addr_o(ram_addr1), .ram_data_i(ram_di1), .ram_data_o(ram_do1),
        .ram_data_oe_o(ram_oe1), .ram_we_n_o(ram_wen1), .ram_oe_n_o(ram_oen1)
    );

    wb_sram_bridge #(.DATA_WIDTH(8), .ADDR_WIDTH(17), .WAIT_STATES(15)) dut2 (
        .wb_clock_i(clk), .wb_reset_n_i(rst_n), .wb(if2),
        .ram_addr_o(ram_addr2), .ram_data_i(ram_di2), .ram_data_o(ram_do2),
        .ram_data_oe_o(ram_oe2), .ram_we_n_o(ram_wen2), .ram_oe_n_o(ram_oen2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: commits on any rising edge that sees write enable low with
    // the pad driven.
    always @(posedge clk) begin
        if (!ram_wen0 && ram_oe0) mem[ram_addr0] <= ram_do0;
    end
    assign ram_di0 = ram_oen0 ? 8'h00 : mem[ram_addr0];
    assign ram_di1 = ram_oen1 ? 8'h00 : 8'hA3;
    assign ram_di2 = ram_oen2 ? 8'h00 : 8'hA3;

    task automatic idle_bus();
        if0.wb_cycle_i = 1'b0; if0.wb_strobe_i = 1'b0; if0.wb_we_i = 1'b0;
        if0.wb_addr_i = '0; if0.wb_data_i = '0;
        if1.wb_cycle_i = 1'b0; if1.wb_strobe_i = 1'b0; if1.wb_we_i = 1'b0;
        if1.wb_addr_i = '0; if1.wb_data_i = '0;
        if2.wb_cycle_i = 1'b0; if2.wb_strobe_i = 1'b0; if2.wb_we_i = 1'b0;
        if2.wb_addr_i = '0; if2.wb_data_i = '0;
    endtask

    task automatic test_reset();
        idle_bus();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({if0.wb_ack_o, if0.wb_stall_o, ram_oe0, ram_wen0, ram_oen0} !== 5'b00011)
            begin errors++; $display("FAIL reset_ctl0: got %b expected 00011", {if0.wb_ack_o, if0.wb_stall_o, ram_oe0, ram_wen0, ram_oen0}); end
        checks++; if ({ram_addr0, ram_do0, if0.wb_data_o} !== 33'd0)
            begin errors++; $display("FAIL reset_data0: addr=%h wdata=%h rdata=%h expected all 0", ram_addr0, ram_do0, if0.wb_data_o); end
        checks++; if ({if1.wb_ack_o, if1.wb_stall_o, ram_wen1, ram_oen1, if1.wb_data_o} !== 12'b0011_0000_0000)
            begin errors++; $display("FAIL reset_dut1: got %b expected 001100000000", {if1.wb_ack_o, if1.wb_stall_o, ram_wen1, ram_oen1, if1.wb_data_o}); end
        checks++; if ({if2.wb_ack_o, if2.wb_stall_o, ram_wen2, ram_oen2, if2.wb_data_o} !== 12'b0011_0000_0000)
            begin errors++; $display("FAIL reset_dut2: got %b expected 001100000000", {if2.wb_ack_o, if2.wb_stall_o, ram_wen2, ram_oen2, if2.wb_data_o}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Write 0x17A5<-0x5C then read it back, W=2.
    task automatic test_write_read();
        for (int op = 0; op < 2; op++) begin
            logic       we;
            logic [7:0] strb_mask, ack_mask;
            int         bad;
            we = (op == 0);
            @(negedge clk);
            if0.wb_cycle_i = 1'b1; if0.wb_strobe_i = 1'b1; if0.wb_we_i = we;
            if0.wb_addr_i = 17'h017A5; if0.wb_data_i = 8'h5C;
            checks++; if (if0.wb_stall_o !== 1'b0)
                begin errors++; $display("FAIL wr_idle_stall op%0d: got %b expected 0", op, if0.wb_stall_o); end
            @(negedge clk);
            if0.wb_strobe_i = 1'b0; if0.wb_data_i = 8'h00;
            checks++; if ({if0.wb_stall_o, if0.wb_ack_o, ram_wen0, ram_oen0, ram_oe0} !== {4'b1011, we})
                begin errors++; $display("FAIL setup_ctl op%0d: got %b expected %b", op, {if0.wb_stall_o, if0.wb_ack_o, ram_wen0, ram_oen0, ram_oe0}, {4'b1011, we}); end
            if (we) begin
                checks++; if (ram_do0 !== 8'h5C)
                    begin errors++; $display("FAIL setup_wdata: got %h expected 5c", ram_do0); end
            end
            strb_mask = '0; ack_mask = '0; bad = 0;
            for (int k = 1; k <= 7; k++) begin
                @(negedge clk);
                if (we ? (ram_wen0 === 1'b0) : (ram_oen0 === 1'b0)) strb_mask[k] = 1'b1;
                if ((we ? ram_oen0 : ram_wen0) !== 1'b1) bad++;
                if (k <= 4 && ram_addr0 !== 17'h017A5) bad++;
                if (ram_oe0 !== ((k <= 4) ? we : 1'b0)) bad++;
                if (if0.wb_ack_o === 1'b1) begin
                    ack_mask[k] = 1'b1;
                    if (!we) begin
                        checks++; if (if0.wb_data_o !== 8'h5C)
                            begin errors++; $display("FAIL read_data: got %h expected 5c", if0.wb_data_o); end
                    end
                end
            end
            checks++; if (strb_mask !== 8'b0000_1110)
                begin errors++; $display("FAIL strobe_window op%0d: got %b expected 00001110", op, strb_mask); end
            checks++; if (ack_mask !== 8'b0001_0000)
                begin errors++; $display("FAIL ack_at_E5 op%0d: got %b expected 00010000", op, ack_mask); end
            checks++; if (bad !== 0)
                begin errors++; $display("FAIL addr_oe_stable op%0d: got %0d violations expected 0", op, bad); end
            if (we) begin
                checks++; if (mem[17'h017A5] !== 8'h5C)
                    begin errors++; $display("FAIL sram_written: got %h expected 5c", mem[17'h017A5]); end
            end else begin
                checks++; if (if0.wb_data_o !== 8'h5C)
                    begin errors++; $display("FAIL read_data_hold: got %h expected 5c", if0.wb_data_o); end
            end
            if0.wb_cycle_i = 1'b0;
        end
    endtask

    // First write 0x0042<-0x11, second write 0x0100<-0x22 held from ACCESS.
    task automatic test_back_to_back();
        logic [15:0] stall_mask, ack_mask, wen_mask;
        int          bad;
        @(negedge clk);
        if0.wb_cycle_i = 1'b1; if0.wb_strobe_i = 1'b1; if0.wb_we_i = 1'b1;
        if0.wb_addr_i = 17'h00042; if0.wb_data_i = 8'h11;
        @(negedge clk);
        if0.wb_strobe_i = 1'b0;
        stall_mask = '0; ack_mask = '0; wen_mask = '0; bad = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (if0.wb_stall_o === 1'b1) stall_mask[k] = 1'b1;
            if (if0.wb_ack_o === 1'b1)   ack_mask[k] = 1'b1;
            if (ram_wen0 === 1'b0)       wen_mask[k] = 1'b1;
            if (k <= 4 && {ram_addr0, ram_do0} !== {17'h00042, 8'h11}) bad++;
            if (k >= 5 && k <= 9 && {ram_addr0, ram_do0, ram_oe0} !== {17'h00100, 8'h22, 1'b1}) bad++;
            if (k == 1) begin
                if0.wb_strobe_i = 1'b1; if0.wb_addr_i = 17'h00100; if0.wb_data_i = 8'h22;
            end
            if (k == 5) if0.wb_strobe_i = 1'b0;
        end
        checks++; if (stall_mask !== 16'h01EE)
            begin errors++; $display("FAIL b2b_stall: got %h expected 01ee", stall_mask); end
        checks++; if (ack_mask !== 16'h0210)
            begin errors++; $display("FAIL b2b_ack: got %h expected 0210", ack_mask); end
        checks++; if (wen_mask !== 16'h01CE)
            begin errors++; $display("FAIL b2b_we_n: got %h expected 01ce", wen_mask); end
        checks++; if (bad !== 0)
            begin errors++; $display("FAIL b2b_addr_data: got %0d violations expected 0", bad); end
        checks++; if ({mem[17'h00042], mem[17'h00100]} !== 16'h1122)
            begin errors++; $display("FAIL b2b_sram: got %h expected 1122", {mem[17'h00042], mem[17'h00100]}); end
        if0.wb_cycle_i = 1'b0;
    endtask

    // Write 0x1FFFF<-0xEE with wb_cycle_i dropped during ACCESS.
    task automatic test_cycle_drop();
        logic [7:0] wen_mask, ack_mask;
        logic       stall_k2, oe_k2;
        @(negedge clk);
        if0.wb_cycle_i = 1'b1; if0.wb_strobe_i = 1'b1; if0.wb_we_i = 1'b1;
        if0.wb_addr_i = 17'h1FFFF; if0.wb_data_i = 8'hEE;
        @(negedge clk);
        if0.wb_strobe_i = 1'b0;
        wen_mask = '0; ack_mask = '0; stall_k2 = 1'b0; oe_k2 = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (ram_wen0 === 1'b0)       wen_mask[k] = 1'b1;
            if (if0.wb_ack_o === 1'b1)   ack_mask[k] = 1'b1;
            if (k == 2) begin stall_k2 = if0.wb_stall_o; oe_k2 = ram_oe0; end
            if (k == 1) if0.wb_cycle_i = 1'b0;
        end
        checks++; if (ack_mask !== 8'h00)
            begin errors++; $display("FAIL drop_no_ack: got %b expected 00000000", ack_mask); end
`ifdef WB_SRAM_ABORT_EN
        checks++; if (wen_mask !== 8'b0000_0010)
            begin errors++; $display("FAIL drop_we_n: got %b expected 00000010", wen_mask); end
        checks++; if ({stall_k2, oe_k2} !== 2'b00)
            begin errors++; $display("FAIL drop_idle: got %b expected 00", {stall_k2, oe_k2}); end
`else
        checks++; if (wen_mask !== 8'b0000_1110)
            begin errors++; $display("FAIL drop_we_n: got %b expected 00001110", wen_mask); end
        checks++; if ({stall_k2, oe_k2} !== 2'b11)
            begin errors++; $display("FAIL drop_busy: got %b expected 11", {stall_k2, oe_k2}); end
        checks++; if (mem[17'h1FFFF] !== 8'hEE)
            begin errors++; $display("FAIL drop_sram: got %h expected ee", mem[17'h1FFFF]); end
`endif
    endtask

    // Reset one edge into ACCESS of a write to 0x0333<-0x77, then read it.
    // The model already committed 0x77 on the reset edge (we_n was low).
    task automatic test_reset_mid_access();
        logic [7:0] ack_mask;
        logic [7:0] rdata;
        @(negedge clk);
        if0.wb_cycle_i = 1'b1; if0.wb_strobe_i = 1'b1; if0.wb_we_i = 1'b1;
        if0.wb_addr_i = 17'h00333; if0.wb_data_i = 8'h77;
        @(negedge clk);
        if0.wb_strobe_i = 1'b0;
        @(negedge clk);
        checks++; if (ram_wen0 !== 1'b0)
            begin errors++; $display("FAIL rst_pre_access: we_n got %b expected 0", ram_wen0); end
        rst_n = 1'b0; if0.wb_cycle_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if ({if0.wb_ack_o, if0.wb_stall_o, ram_oe0, ram_wen0, ram_oen0} !== 5'b00011)
            begin errors++; $display("FAIL rst_mid_ctl: got %b expected 00011", {if0.wb_ack_o, if0.wb_stall_o, ram_oe0, ram_wen0, ram_oen0}); end
        checks++; if ({ram_addr0, ram_do0, if0.wb_data_o} !== 33'd0)
            begin errors++; $display("FAIL rst_mid_data: addr=%h wdata=%h rdata=%h expected all 0", ram_addr0, ram_do0, if0.wb_data_o); end
        if0.wb_cycle_i = 1'b1; if0.wb_strobe_i = 1'b1; if0.wb_we_i = 1'b0;
        @(negedge clk);
        if0.wb_strobe_i = 1'b0;
        ack_mask = '0; rdata = 8'h00;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (if0.wb_ack_o === 1'b1) begin ack_mask[k] = 1'b1; rdata = if0.wb_data_o; end
        end
        checks++; if (ack_mask !== 8'b0001_0000)
            begin errors++; $display("FAIL rst_reread_ack: got %b expected 00010000", ack_mask); end
        checks++; if (rdata !== 8'h77)
            begin errors++; $display("FAIL rst_reread_data: got %h expected 77", rdata); end
        if0.wb_cycle_i = 1'b0;
    endtask

    // Read 0x00000 on the W=0 and W=15 instances concurrently.
    task automatic test_wait_extremes();
        int         k1, k2, n_ack1, n_ack2, n_oe1, n_oe2;
        logic [7:0] d1, d2;
        @(negedge clk);
        if1.wb_cycle_i = 1'b1; if1.wb_strobe_i = 1'b1; if1.wb_we_i = 1'b0; if1.wb_addr_i = '0;
        if2.wb_cycle_i = 1'b1; if2.wb_strobe_i = 1'b1; if2.wb_we_i = 1'b0; if2.wb_addr_i = '0;
        @(negedge clk);
        if1.wb_strobe_i = 1'b0; if2.wb_strobe_i = 1'b0;
        k1 = 0; k2 = 0; n_ack1 = 0; n_ack2 = 0; n_oe1 = 0; n_oe2 = 0; d1 = 8'h00; d2 = 8'h00;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ram_oen1 === 1'b0) n_oe1++;
            if (ram_oen2 === 1'b0) n_oe2++;
            if (if1.wb_ack_o === 1'b1) begin n_ack1++; if (k1 == 0) begin k1 = k; d1 = if1.wb_data_o; end end
            if (if2.wb_ack_o === 1'b1) begin n_ack2++; if (k2 == 0) begin k2 = k; d2 = if2.wb_data_o; end end
        end
        checks++; if (k1 + 1 !== 3 || n_ack1 !== 1)
            begin errors++; $display("FAIL w0_latency: ack at E%0d count %0d expected E3 count 1", k1 + 1, n_ack1); end
        checks++; if (d1 !== 8'hA3)
            begin errors++; $display("FAIL w0_data: got %h expected a3", d1); end
        checks++; if (n_oe1 !== 1)
            begin errors++; $display("FAIL w0_oe_len: got %0d expected 1", n_oe1); end
        checks++; if (k2 + 1 !== 18 || n_ack2 !== 1)
            begin errors++; $display("FAIL w15_latency: ack at E%0d count %0d expected E18 count 1", k2 + 1, n_ack2); end
        checks++; if (d2 !== 8'hA3)
            begin errors++; $display("FAIL w15_data: got %h expected a3", d2); end
        checks++; if (n_oe2 !== 16)
            begin errors++; $display("FAIL w15_oe_len: got %0d expected 16", n_oe2); end
        if1.wb_cycle_i = 1'b0; if2.wb_cycle_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_bus();
        test_reset();
        test_write_read();
        test_back_to_back();
        test_cycle_drop();
        test_reset_mid_access();
        test_wait_extremes();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
